// File: rtl/serial_adder_seq_if.sv
// Operand/result bundle for serial_adder_seq.
// master drives the request side, slave is the adder.
interface serial_adder_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, sub, a, b, cin,
    input  sum, cout, ovf, busy, done
  );

  modport slave (
    input  start, sub, a, b, cin,
    output sum, cout, ovf, busy, done
  );
endinterface

// File: rtl/serial_adder_seq.sv
// Multi-cycle add/subtract: one DIGIT-wide full-adder slice iterated LSB first,
// with start/busy/done handshake and registered sum/cout/ovf.
module serial_adder_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input logic               clk,
  input logic               rst,
  serial_adder_seq_if.slave bus
);
  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned MSB   = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] beff_q;
  logic [WIDTH-1:0] res_q;
  logic             a_msb;
  logic             b_msb;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic [DIGIT-1:0] s_dig;
  logic             c_nxt;
  logic [WIDTH-1:0] res_nxt;

  // Digit slice: operands shift right so the active digit is always the low one.
  always_comb begin
    {c_nxt, s_dig} = (DIGIT+1)'(a_q[DIGIT-1:0]) + (DIGIT+1)'(beff_q[DIGIT-1:0])
                   + (DIGIT+1)'(carry_q);
    res_nxt = (res_q >> DIGIT) | (WIDTH'(s_dig) << (WIDTH - DIGIT));
  end

  // busy/done trail the state by one cycle so done lands STEPS+1 edges after start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      beff_q  <= '0;
      res_q   <= '0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q <= (state != IDLE);
      done_q <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            beff_q  <= bus.sub ? ~bus.b : bus.b;
            a_msb   <= bus.a[MSB];
            b_msb   <= bus.b[MSB] ^ bus.sub;
            carry_q <= bus.cin ^ bus.sub;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          beff_q  <= beff_q >> DIGIT;
          res_q   <= res_nxt;
          carry_q <= c_nxt;
          cnt     <= cnt + CW'(1);
          if (cnt == CW'(STEPS - 1)) begin
            sum_q  <= res_nxt;
            cout_q <= c_nxt;
            ovf_q  <= (a_msb == b_msb) && (res_nxt[MSB] != a_msb);
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
- Parametrised, multi-cycle successor to the single-bit behavioural full adder.
- Adds or subtracts two WIDTH-bit operands, DIGIT bits per clock, LSB first.
- A single registered full-adder slice of DIGIT bits carries the result between cycles.
- Start/busy/done handshake; used where area matters more than latency (accumulators, checksum paths).

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits processed per clock; 1 <= DIGIT <= WIDTH.
- STEPS (local, derived), WIDTH/DIGIT, number of compute cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = a+b+cin; 1 = a-b-cin (b inverted internally).
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- cin  input  1  carry-in (add) or borrow-in (sub); latched on accepted start.
- sum  output  WIDTH  result; registered, holds last completed result.
- cout  output  1  carry-out (add) or NOT borrow (sub).
- ovf  output  1  signed two's-complement overflow.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE, sum=0, cout=0, ovf=0, busy=0, done=0, step counter=0, internal carry=0.
- States:
  - IDLE: busy=0. If start=1 at an edge, latch a, b, cin and sub; set carry=cin^sub; counter=0; go to RUN.
  - RUN: busy=1. Each cycle, take digit [counter*DIGIT +: DIGIT] of a and of (sub ? ~b : b). Add them with the stored carry and shift the DIGIT result bits into the internal result register. The new carry is stored; counter increments. On the cycle where counter==STEPS-1, go to DONE.
  - DONE: one cycle. busy=1, done=1. Then return to IDLE.
- Output update:
  - Copy the internal result to sum on the RUN->DONE edge.
  - Set cout to the final carry on the same edge.
  - ovf = (a[MSB] == b_eff[MSB]) && (result[MSB] != a[MSB]), where b_eff = (sub ? ~b : b).
  - sum, cout and ovf stay stable through the next operation until its own RUN->DONE edge; they never show partial results.
- Latency: start sampled at edge 0 -> done=1 during the cycle following edge STEPS+1. The next start is accepted no earlier than edge STEPS+2.
- start while busy (RUN or DONE): ignored. Not queued, no error.
- Inputs a, b, cin and sub may change freely after acceptance; only the latched copies are used.
- sub=1, cin=0: plain a-b. cout=1 means no borrow (a >= b, unsigned).
- Reset asserted mid-RUN or in DONE:
  - Aborts the operation; no done pulse.
  - sum, cout and ovf return to 0 on that edge.
  - start is ignored while rst=1.
- Wrap-around: the result is modulo 2^WIDTH; the carry beyond the MSB appears only on cout.
- DIGIT=WIDTH is legal: STEPS=1; done follows 2 edges after start.

Test Plan:
- WIDTH=8, DIGIT=1, add a=0x5A b=0x3C cin=0 -> sum=0x96, cout=0, ovf=1. done high exactly one cycle, 9 edges after start sampled; busy high 9 cycles.
- Add a=0xFF b=0x01 cin=0 -> sum=0x00, cout=1, ovf=0. Then add a=0x7F b=0x00 cin=1 -> sum=0x80, ovf=1. Previous sum holds 0x00 until the second done.
- Sub a=0x10 b=0x20 cin=0 -> sum=0xF0, cout=0, ovf=0. Sub a=0x80 b=0x01 -> sum=0x7F, cout=1, ovf=1. Sub a=0x05 b=0x05 cin=1 -> sum=0xFF, cout=0.
- Pulse start again during RUN with different operands -> ignored; first result unchanged. A start held high continuously -> back-to-back operations every STEPS+2 cycles.
- Assert rst for one cycle at RUN step 4 -> no done, sum/cout/ovf=0, busy=0 next cycle. A new start then completes normally.
- WIDTH=16, DIGIT=4: a=0xFFFF b=0x0001 add -> sum=0x0000, cout=1, done 5 edges after start. Random 1000-vector compare against a+b+cin and a-b-cin reference for DIGIT in {1,2,4,16}.
